// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// States, opcode/funct values and datapath mux selects live here.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: selects the ALU operation and flags functs
// this core does not implement.
module mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multicycle MIPS controller: sequences fetch/decode/execute/
// memory/writeback over a shared ALU and memory port, counting retirements.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int SUPPORT_BNE = 1,
    parameter int ALUCTL_W    = 3,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                i_or_d,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_en,
    output logic                reg_dst,
    output logic                memto_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [1:0]          pc_src,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_retired
);

    state_t     state, next_state;
    logic       pc_write, branch, taken, retire;
    logic [2:0] alu_sel, funct_op;
    logic       funct_bad;

    mc_alu_decoder u_alu_dec (
        .funct   (funct),
        .alu_op  (funct_op),
        .illegal (funct_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_sel    = ALU_ADD;
        pc_src     = PC_ALU;
        illegal_op = 1'b0;
        retire     = 1'b0;
        case (state)
            INIT: begin
                alu_sel    = 3'b000;
                next_state = FETCH;
            end
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed into ALU-out while decoding.
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_BNE: begin
                        if (SUPPORT_BNE != 0) begin
                            next_state = BRANCH;
                        end else begin
                            illegal_op = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                memto_reg  = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_sel   = funct_op;
                if (funct_bad) begin
                    illegal_op = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = ALUWB;
                end
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_sel    = ALU_SUB;
                pc_src     = PC_ALUOUT;
                branch     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = INIT;
        endcase
    end

    // The only opcode reaching BRANCH besides beq is bne, so invert for it.
    assign taken       = (opcode == OP_BNE) ? ~zero : zero;
    assign pc_en       = pc_write | (branch & taken);
    assign alu_control = ALUCTL_W'(alu_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_retired <= '0;
        else if (retire) instr_retired <= instr_retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction event summaries checked
// against a table and against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;

    logic        mem_req, i_or_d, mem_write, ir_write, pc_en, reg_dst, memto_reg;
    logic        reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic [31:0] instr_retired;

    logic        nb_mem_req, nb_i_or_d, nb_mem_write, nb_ir_write, nb_pc_en, nb_reg_dst;
    logic        nb_memto_reg, nb_reg_write, nb_alu_src_a, nb_illegal_op;
    logic [1:0]  nb_alu_src_b, nb_pc_src;
    logic [2:0]  nb_alu_control;
    logic [31:0] nb_instr_retired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.SUPPORT_BNE(1), .ALUCTL_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d),
        .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .illegal_op(illegal_op), .instr_retired(instr_retired)
    );

    mips_multicycle_ctrl #(.SUPPORT_BNE(0), .ALUCTL_W(3), .CNT_W(32)) dut_nobne (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(nb_mem_req), .i_or_d(nb_i_or_d),
        .mem_write(nb_mem_write), .ir_write(nb_ir_write), .pc_en(nb_pc_en),
        .reg_dst(nb_reg_dst), .memto_reg(nb_memto_reg), .reg_write(nb_reg_write),
        .alu_src_a(nb_alu_src_a), .alu_src_b(nb_alu_src_b), .alu_control(nb_alu_control),
        .pc_src(nb_pc_src), .illegal_op(nb_illegal_op), .instr_retired(nb_instr_retired)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         z;
        int         fw;
        int         mw;
    } instr_t;

    typedef struct {
        int cycles; int rw; int wb_at; int memto; int rdst; int memw;
        int pcen; int pcsrc; int irw; int ill; int ret; int alu;
    } expect_t;

    typedef struct {
        instr_t  in;
        expect_t ex;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int alu_code(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    // Instruction-level reference: latency, side-effect counts and retirement.
    function automatic expect_t model(input instr_t i, input bit bne_ok);
        expect_t e;
        int      code;
        bit      br, tk;
        e = '{default: 0};
        e.alu  = -1;
        e.pcen = 1;
        e.irw  = 1;
        br = 1'b0;
        tk = 1'b0;
        if (i.op == 6'b100011) begin
            e.cycles = 5 + i.fw + i.mw; e.rw = 1; e.wb_at = e.cycles; e.memto = 1; e.ret = 1;
        end else if (i.op == 6'b101011) begin
            e.cycles = 4 + i.fw + i.mw; e.memw = 1; e.ret = 1;
        end else if (i.op == 6'b000000) begin
            code = alu_code(i.fn);
            if (code < 0) begin
                e.cycles = 3 + i.fw; e.ill = 1;
            end else begin
                e.cycles = 4 + i.fw; e.rw = 1; e.wb_at = e.cycles; e.rdst = 1;
                e.ret = 1; e.alu = code;
            end
        end else if (i.op == 6'b000100) begin
            br = 1'b1; tk = i.z;
        end else if (i.op == 6'b000101 && bne_ok) begin
            br = 1'b1; tk = !i.z;
        end else if (i.op == 6'b001000) begin
            e.cycles = 4 + i.fw; e.rw = 1; e.wb_at = e.cycles; e.ret = 1;
        end else if (i.op == 6'b000010) begin
            e.cycles = 3 + i.fw; e.pcen = 2; e.pcsrc = 2; e.ret = 1;
        end else begin
            e.cycles = 2 + i.fw; e.ill = 1;
        end
        if (br) begin
            e.cycles = 3 + i.fw; e.ret = 1; e.alu = 6;
            if (tk) begin e.pcen = 2; e.pcsrc = 1; end
        end
        return e;
    endfunction

    // Entered right after a negedge with the DUT in FETCH; leaves at the
    // negedge where the next FETCH begins, mem_ready not yet driven.
    task automatic run_instr(input instr_t in, output expect_t o);
        int          cyc, fcnt, dcnt;
        bit          left, done;
        logic [31:0] r0;
        cyc = 0; fcnt = 0; dcnt = 0; left = 1'b0; done = 1'b0;
        o = '{default: 0};
        o.alu = -1;
        opcode = in.op; funct = in.fn; zero = in.z;
        r0 = instr_retired;
        while (!done) begin
            if (cyc > 0) @(negedge clk);
            if (left && mem_req && !i_or_d) begin
                done = 1'b1;
            end else if (cyc >= 60) begin
                check("instr_timeout", cyc, 0);
                done = 1'b1;
            end else begin
                if (mem_req && !i_or_d) begin
                    mem_ready = (fcnt >= in.fw); fcnt++;
                end else if (mem_req) begin
                    mem_ready = (dcnt >= in.mw); dcnt++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                cyc++;
                if (!(mem_req && !i_or_d)) left = 1'b1;
                if (reg_write) begin
                    o.rw++; o.wb_at = cyc; o.memto = int'(memto_reg); o.rdst = int'(reg_dst);
                end
                if (mem_write && mem_ready) o.memw++;
                if (mem_write && !mem_req)  o.memw += 100;
                if (pc_en) begin o.pcen++; o.pcsrc = int'(pc_src); end
                if (ir_write)   o.irw++;
                if (illegal_op) o.ill++;
                if (alu_src_a && alu_src_b == 2'b00 && o.alu < 0) o.alu = int'(alu_control);
            end
        end
        o.cycles = cyc;
        o.ret    = int'(instr_retired - r0);
    endtask

    task automatic compare(input string nm, input expect_t o, input expect_t e);
        check({nm, ".cycles"}, o.cycles, e.cycles);
        check({nm, ".reg_write"}, o.rw, e.rw);
        check({nm, ".wb_cycle"}, o.wb_at, e.wb_at);
        check({nm, ".memto_reg"}, o.memto, e.memto);
        check({nm, ".reg_dst"}, o.rdst, e.rdst);
        check({nm, ".mem_write"}, o.memw, e.memw);
        check({nm, ".pc_en"}, o.pcen, e.pcen);
        check({nm, ".pc_src"}, o.pcsrc, e.pcsrc);
        check({nm, ".ir_write"}, o.irw, e.irw);
        check({nm, ".illegal"}, o.ill, e.ill);
        check({nm, ".retired"}, o.ret, e.ret);
        if (e.alu >= 0) check({nm, ".alu_control"}, o.alu, e.alu);
    endtask

    function automatic int all_outputs();
        return int'({mem_req, i_or_d, mem_write, ir_write, pc_en, reg_dst, memto_reg,
                     reg_write, alu_src_a, alu_src_b, alu_control, pc_src, illegal_op});
    endfunction

    // Leaves the bench positioned at the first FETCH cycle.
    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        @(negedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        check("reset_retired", int'(instr_retired), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_outputs", all_outputs(), 0);
        check("init_nobne_req", int'(nb_mem_req), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vecs[14];
        expect_t o, e;
        instr_t  ri;
        logic [5:0] ops[9];
        logic [5:0] fns[7];
        int ill0, pc0;

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                6'b001000, 6'b000010, 6'b111111, 6'b001101};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b000000, 6'b100111};

        // cycles rw wb_at memto rdst memw pcen pcsrc irw ill ret alu
        vecs[0]  = '{'{6'b100011, 6'b000000, 1'b0, 2, 2}, '{9, 1, 9, 1, 0, 0, 1, 0, 1, 0, 1, -1}};
        vecs[1]  = '{'{6'b101011, 6'b000000, 1'b0, 1, 3}, '{8, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, -1}};
        vecs[2]  = '{'{6'b000000, 6'b101010, 1'b0, 0, 0}, '{4, 1, 4, 0, 1, 0, 1, 0, 1, 0, 1, 7}};
        vecs[3]  = '{'{6'b000000, 6'b100010, 1'b0, 1, 0}, '{5, 1, 5, 0, 1, 0, 1, 0, 1, 0, 1, 6}};
        vecs[4]  = '{'{6'b000100, 6'b000000, 1'b1, 0, 0}, '{3, 0, 0, 0, 0, 0, 2, 1, 1, 0, 1, 6}};
        vecs[5]  = '{'{6'b000100, 6'b000000, 1'b0, 0, 0}, '{3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 6}};
        vecs[6]  = '{'{6'b000101, 6'b000000, 1'b0, 0, 0}, '{3, 0, 0, 0, 0, 0, 2, 1, 1, 0, 1, 6}};
        vecs[7]  = '{'{6'b000101, 6'b000000, 1'b1, 0, 0}, '{3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 6}};
        vecs[8]  = '{'{6'b001000, 6'b000000, 1'b0, 0, 0}, '{4, 1, 4, 0, 0, 0, 1, 0, 1, 0, 1, -1}};
        vecs[9]  = '{'{6'b000010, 6'b000000, 1'b0, 0, 0}, '{3, 0, 0, 0, 0, 0, 2, 2, 1, 0, 1, -1}};
        vecs[10] = '{'{6'b111111, 6'b000000, 1'b0, 0, 0}, '{2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, -1}};
        vecs[11] = '{'{6'b000000, 6'b000000, 1'b0, 0, 0}, '{3, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, -1}};
        vecs[12] = '{'{6'b000000, 6'b100100, 1'b0, 0, 0}, '{4, 1, 4, 0, 1, 0, 1, 0, 1, 0, 1, 0}};
        vecs[13] = '{'{6'b000000, 6'b100101, 1'b0, 3, 0}, '{7, 1, 7, 0, 1, 0, 1, 0, 1, 0, 1, 1}};

        do_reset();

        for (int v = 0; v < 14; v++) begin
            run_instr(vecs[v].in, o);
            compare($sformatf("vec%0d", v), o, vecs[v].ex);
        end

        for (int n = 0; n < 60; n++) begin
            ri.op = ops[$urandom_range(0, 8)];
            ri.fn = fns[$urandom_range(0, 6)];
            ri.z  = 1'($urandom_range(0, 1));
            ri.fw = $urandom_range(0, 3);
            ri.mw = $urandom_range(0, 3);
            e = model(ri, 1'b1);
            run_instr(ri, o);
            compare($sformatf("rnd%0d_op%b", n, ri.op), o, e);
        end

        // sw abandoned by reset while stalled in the data write
        check("retired_nonzero", int'(instr_retired != 0), 1);
        opcode = 6'b101011; funct = 6'd0; zero = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sw_wr_req", int'({mem_req, i_or_d, mem_write}), 7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_rst_req", int'(mem_req), 0);
        check("sw_rst_write", int'(mem_write), 0);
        check("sw_rst_retired", int'(instr_retired), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sw_rst_init", all_outputs(), 0);
        @(negedge clk);
        #1;
        check("sw_rst_fetch", int'({mem_req, i_or_d}), 2);

        // bne with and without bne support, zero=0
        do_reset();
        opcode = 6'b000101; funct = 6'd0; zero = 1'b0;
        ill0 = 0; pc0 = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            mem_ready = 1'b1;
            #1;
            if (c <= 2) begin
                ill0 += int'(nb_illegal_op);
                pc0  += int'(nb_pc_en);
            end
            check($sformatf("nobne_writes_c%0d", c), int'({nb_reg_write, nb_mem_write}), 0);
            if (c == 3) begin
                check("nobne_back_fetch", int'({nb_mem_req, nb_i_or_d, nb_illegal_op}), 4);
                check("bne_taken_pc_en", int'(pc_en), 1);
                check("bne_pc_src", int'(pc_src), 1);
            end
        end
        check("nobne_illegal", ill0, 1);
        check("nobne_pc_en", pc0, 1);
        @(negedge clk);
        #1;
        check("nobne_retired", int'(nb_instr_retired), 0);
        check("bne_retired", int'(instr_retired), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control unit that replaces the single-cycle main/ALU decoder pair. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback over 3-5+ cycles, sharing one ALU and one memory port. It adds a memory ready handshake for wait states, optional bne support, illegal-instruction flagging and a retired-instruction counter. It sits between the instruction register and the multicycle datapath.

Parameters:
SUPPORT_BNE, 1, 1 = opcode 000101 is decoded as bne; 0 = it is flagged illegal.
ALUCTL_W, 3, width of alu_control (encodings add 010, sub 110, and 000, or 001, slt 111).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires.
funct  in  6  IR[5:0].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory has completed the current access this cycle.
mem_req  out  1  memory access request, held until mem_ready.
i_or_d  out  1  0 = PC address, 1 = ALU-out address.
mem_write  out  1  write strobe, valid only while mem_req is high.
ir_write  out  1  load the IR.
pc_en  out  1  pc_write | (branch & taken).
reg_dst  out  1  1 = rd, 0 = rt.
memto_reg  out  1  1 = memory data, 0 = ALU-out.
reg_write  out  1  register file write.
alu_src_a  out  1  0 = PC, 1 = register A.
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
alu_control  out  ALUCTL_W  ALU operation.
pc_src  out  2  00 ALU result, 01 ALU-out, 10 jump target.
illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n low): state = INIT, instr_retired = 0, and every output is 0. INIT lasts one cycle with all outputs 0, then moves to FETCH.
- Any output not listed for a state is 0. The default alu_control is add.
- FETCH: mem_req=1, i_or_d=0, src_a=0, src_b=01, add. If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay; ir_write and pc_write are 0 while waiting.
- DECODE: src_a=0, src_b=11, add (branch target into ALU-out). Next state by opcode:
  - 100011 or 101011 -> MEMADR.
  - 000000 -> EXECUTE.
  - 000100 -> BRANCH.
  - 000101 -> BRANCH if SUPPORT_BNE=1.
  - 001000 -> ADDIEX.
  - 000010 -> JUMP.
  - Any other opcode: illegal_op=1, go to FETCH. No writes occur and instr_retired is not incremented.
- MEMADR: src_a=1, src_b=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, i_or_d=1. mem_ready -> MEMWB; otherwise stay.
- MEMWB: reg_dst=0, memto_reg=1, reg_write=1, then FETCH.
- MEMWR: mem_req=1, i_or_d=1, mem_write=1. mem_ready -> FETCH; otherwise stay.
- EXECUTE: src_a=1, src_b=00. alu_control from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Then ALUWB.
  - Unknown funct: illegal_op=1, go to FETCH, no writeback.
- ALUWB: reg_dst=1, memto_reg=0, reg_write=1, then FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01, branch=1. taken = zero for beq, !zero for bne; pc_en = taken. Then FETCH.
- ADDIEX: src_a=1, src_b=10, add, then ADDIWB.
- ADDIWB: reg_dst=0, memto_reg=0, reg_write=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- instr_retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- There is no timeout: the FSM waits indefinitely for mem_ready.
- Reset mid-access drops mem_req asynchronously; the access is abandoned with no retry.
- Latencies in cycles (excluding wait states): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum (INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP);
  - opcode and funct localparams;
  - alu_control, alu_src_b and pc_src encodings.
- Sub-module mc_alu_decoder: combinational funct -> alu_control plus an illegal-funct flag. It is instantiated once.

Test Plan:
- lw, opcode 100011, with mem_ready low for 2 cycles in both FETCH and MEMRD -> reg_write=1 with memto_reg=1 on cycle 9 after INIT exits; instr_retired goes 0 -> 1.
- R-type, funct 101010 -> alu_control=111 in EXECUTE; reg_write=1 with reg_dst=1 in the next cycle; 4 cycles total.
- beq with zero=1, then beq with zero=0 -> pc_en=1 and pc_en=0 respectively in BRANCH, pc_src=01.
- Opcode 000101 with zero=0: SUPPORT_BNE=1 gives pc_en=1; SUPPORT_BNE=0 gives illegal_op pulse, no pc_en, and instr_retired unchanged.
- sw with rst_n low mid-MEMWR -> mem_req and mem_write drop immediately, instr_retired=0, one INIT cycle, then FETCH with mem_req=1.
- Opcode 111111, and funct 000000 under opcode 000000 -> illegal_op=1 for exactly one cycle, then FETCH; reg_write and mem_write stay 0 throughout.
